tdm_demux4: RTL

//  Receive side of the 4:1 select-line multiplexer link. Drives the remote mux selects
//  (o_a1:o_a0), samples its single output line i_y once per slot, and rebuilds the four

---
 rtl/tdm_pkg.sv | 20 ++
 rtl/tdm_slot_timer.sv | 33 +++
 rtl/tdm_demux4.sv | 111 +++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package tdm_pkg;

   localparam int unsigned SLOT_W    = 2;
   localparam int unsigned NUM_SLOTS = 4;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUNT = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Counter width that stays legal when only one count value exists.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// Per-slot cycle counter: counts 0..SLOT_CYC-1 and flags the last cycle of a slot.
module tdm_slot_timer
   import tdm_pkg::*;
#(
   parameter int unsigned SLOT_CYC = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic slot_end_c
);

   localparam int unsigned      CNT_W    = cnt_width(SLOT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);

   logic [CNT_W-1:0] cnt;

   // Slot ends on the last count while the timer is running.
   assign slot_end_c = en && (cnt == CNT_LAST);

   // Count cycles within a slot; clear holds or restarts the slot at count 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= slot_end_c ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 select-line mux link: drives selects, samples i_y once per
// slot and publishes the four channels together at each frame boundary.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int unsigned DATA_W   = 1,
   parameter int unsigned SLOT_CYC = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_sync,
   input  logic [DATA_W-1:0] i_y,
   output logic              o_a1,
   output logic              o_a0,
   output logic [DATA_W-1:0] o_d0,
   output logic [DATA_W-1:0] o_d1,
   output logic [DATA_W-1:0] o_d2,
   output logic [DATA_W-1:0] o_d3,
   output logic              o_frame_valid,
   output logic              o_sync_err
);

   state_t                             state;
   logic [SLOT_W-1:0]                  slot;
   logic [NUM_SLOTS-2:0][DATA_W-1:0]   shadow;

   logic run_c;
   logic slot_end_c;
   logic frame_end_c;
   logic resync_c;
   logic timer_clr_c;

   // Slot decode: a sync that does not coincide with the end of slot 3 is a resync.
   assign run_c       = (state == RUN) && i_en;
   assign frame_end_c = run_c && slot_end_c && (slot == LAST_SLOT);
   assign resync_c    = run_c && i_sync && !frame_end_c;
   assign timer_clr_c = !run_c || resync_c;

   // The slot register itself drives the selects, so they change only on clock edges.
   assign o_a1 = slot[1];
   assign o_a0 = slot[0];

   tdm_slot_timer #(
      .SLOT_CYC (SLOT_CYC)
   ) u_slot_timer (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .clr        (timer_clr_c),
      .en         (run_c),
      .slot_end_c (slot_end_c)
   );

   // Link FSM with slot sequencing, shadow capture and frame publication.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         slot          <= '0;
         shadow        <= '0;
         o_d0          <= '0;
         o_d1          <= '0;
         o_d2          <= '0;
         o_d3          <= '0;
         o_frame_valid <= 1'b0;
         o_sync_err    <= 1'b0;
      end else begin
         o_frame_valid <= 1'b0;
         o_sync_err    <= 1'b0;
         if (!i_en) begin
            state <= IDLE;
            slot  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state <= HUNT;
               end
               HUNT: begin
                  if (i_sync) begin
                     state <= RUN;
                     slot  <= '0;
                  end
               end
               RUN: begin
                  if (resync_c) begin
                     // Drop the partial frame and restart slot 0 from this edge.
                     o_sync_err <= 1'b1;
                     slot       <= '0;
                  end else if (slot_end_c) begin
                     slot <= slot + SLOT_W'(1);
                     if (slot == LAST_SLOT) begin
                        // Slot 3 bypasses the shadow so all four words land together.
                        o_d0          <= shadow[0];
                        o_d1          <= shadow[1];
                        o_d2          <= shadow[2];
                        o_d3          <= i_y;
                        o_frame_valid <= 1'b1;
                     end else begin
                        shadow[slot] <= i_y;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  slot  <= '0;
               end
            endcase
         end
      end
   end

endmodule
